// File: rtl/ysyx_22050710_wb_stage.sv
// Write-back stage: latches the retiring instruction from the memory stage and drives
// the GPR/CSR write ports, the decode forwarding bus, the commit port and the instret counter.
module ysyx_22050710_wb_stage #(
   parameter int WORD_WD         = 64,
   parameter int PC_WD           = 64,
   parameter int INST_WD         = 32,
   parameter int GPR_ADDR_WD     = 5,
   parameter int CSR_ADDR_WD     = 12,
   parameter int MS_TO_WS_BUS_WD = 2 + GPR_ADDR_WD + CSR_ADDR_WD + 2*WORD_WD,
   parameter int BYPASS_BUS_WD   = GPR_ADDR_WD + CSR_ADDR_WD + 2*WORD_WD,
   parameter int DEBUG_BUS_WD    = INST_WD + 2*PC_WD + 1 + WORD_WD
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   output logic                       o_ws_allowin,
   input  logic                       i_ms_to_ws_valid,
   input  logic [MS_TO_WS_BUS_WD-1:0] i_ms_to_ws_bus,
   input  logic [DEBUG_BUS_WD-1:0]    i_debug_ms_to_ws_bus,
   input  logic                       i_commit_ready,
   output logic                       o_rf_wen,
   output logic [GPR_ADDR_WD-1:0]     o_rf_waddr,
   output logic [WORD_WD-1:0]         o_rf_wdata,
   output logic                       o_csr_wen,
   output logic [CSR_ADDR_WD-1:0]     o_csr_waddr,
   output logic [WORD_WD-1:0]         o_csr_wdata,
   output logic [BYPASS_BUS_WD-1:0]   o_ws_to_ds_bypass_bus,
   output logic                       o_commit_valid,
   output logic [PC_WD-1:0]           o_commit_pc,
   output logic [INST_WD-1:0]         o_commit_inst,
   output logic [PC_WD-1:0]           o_commit_dnpc,
   output logic                       o_commit_memen,
   output logic [WORD_WD-1:0]         o_commit_memaddr,
   output logic [63:0]                o_instret
);

   // ms bus field offsets, LSB first: csr_result, csr, csr_wen, gpr_result, rd, gpr_wen
   localparam int MS_CSR_RES_LSB = 0;
   localparam int MS_CSR_LSB     = MS_CSR_RES_LSB + WORD_WD;
   localparam int MS_CSR_WEN_BIT = MS_CSR_LSB + CSR_ADDR_WD;
   localparam int MS_GPR_RES_LSB = MS_CSR_WEN_BIT + 1;
   localparam int MS_RD_LSB      = MS_GPR_RES_LSB + WORD_WD;
   localparam int MS_GPR_WEN_BIT = MS_RD_LSB + GPR_ADDR_WD;

   // debug bus field offsets, LSB first: memaddr, memen, dnpc, pc, inst
   localparam int DBG_MEMADDR_LSB = 0;
   localparam int DBG_MEMEN_BIT   = DBG_MEMADDR_LSB + WORD_WD;
   localparam int DBG_DNPC_LSB    = DBG_MEMEN_BIT + 1;
   localparam int DBG_PC_LSB      = DBG_DNPC_LSB + PC_WD;
   localparam int DBG_INST_LSB    = DBG_PC_LSB + PC_WD;

   logic                       ws_valid_reg;
   logic [MS_TO_WS_BUS_WD-1:0] ms_bus_reg;
   logic [DEBUG_BUS_WD-1:0]    debug_bus_reg;
   logic [63:0]                instret_reg;
   logic [63:0]                instret_next;

   logic                       ws_ready_go;
   logic                       retire;
   logic                       gpr_wen;
   logic [GPR_ADDR_WD-1:0]     rd;
   logic [WORD_WD-1:0]         gpr_result;
   logic                       csr_wen;
   logic [CSR_ADDR_WD-1:0]     csr;
   logic [WORD_WD-1:0]         csr_result;

   assign ws_ready_go  = i_commit_ready;
   assign o_ws_allowin = !ws_valid_reg || ws_ready_go;
   assign retire       = ws_valid_reg && ws_ready_go;
   assign instret_next = instret_reg + 64'd1;

   assign gpr_wen    = ms_bus_reg[MS_GPR_WEN_BIT];
   assign rd         = ms_bus_reg[MS_RD_LSB +: GPR_ADDR_WD];
   assign gpr_result = ms_bus_reg[MS_GPR_RES_LSB +: WORD_WD];
   assign csr_wen    = ms_bus_reg[MS_CSR_WEN_BIT];
   assign csr        = ms_bus_reg[MS_CSR_LSB +: CSR_ADDR_WD];
   assign csr_result = ms_bus_reg[MS_CSR_RES_LSB +: WORD_WD];

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         ws_valid_reg  <= 1'b0;
         ms_bus_reg    <= '0;
         debug_bus_reg <= '0;
         instret_reg   <= '0;
      end else begin
         if (o_ws_allowin) begin
            ws_valid_reg <= i_ms_to_ws_valid;
         end
         if (i_ms_to_ws_valid && o_ws_allowin) begin
            ms_bus_reg    <= i_ms_to_ws_bus;
            debug_bus_reg <= i_debug_ms_to_ws_bus;
         end
         if (retire) begin
            instret_reg <= instret_next;
         end
      end
   end

   // x0 is hardwired to zero, so its writes never reach the register file
   assign o_rf_wen    = retire && gpr_wen && (rd != '0);
   assign o_rf_waddr  = rd;
   assign o_rf_wdata  = gpr_result;
   assign o_csr_wen   = retire && csr_wen;
   assign o_csr_waddr = csr;
   assign o_csr_wdata = csr_result;

   // Forwarding is gated by ws_valid rather than retire so a stalled result still bypasses
   always_comb begin
      o_ws_to_ds_bypass_bus = '0;
      if (ws_valid_reg) begin
         if (gpr_wen) begin
            o_ws_to_ds_bypass_bus[BYPASS_BUS_WD-1 -: GPR_ADDR_WD]               = rd;
            o_ws_to_ds_bypass_bus[BYPASS_BUS_WD-GPR_ADDR_WD-1 -: WORD_WD]       = gpr_result;
         end
         if (csr_wen) begin
            o_ws_to_ds_bypass_bus[WORD_WD +: CSR_ADDR_WD] = csr;
            o_ws_to_ds_bypass_bus[0 +: WORD_WD]           = csr_result;
         end
      end
   end

   assign o_commit_valid   = retire;
   assign o_commit_inst    = debug_bus_reg[DBG_INST_LSB +: INST_WD];
   assign o_commit_pc      = debug_bus_reg[DBG_PC_LSB +: PC_WD];
   assign o_commit_dnpc    = debug_bus_reg[DBG_DNPC_LSB +: PC_WD];
   assign o_commit_memen   = debug_bus_reg[DBG_MEMEN_BIT];
   assign o_commit_memaddr = debug_bus_reg[DBG_MEMADDR_LSB +: WORD_WD];
   assign o_instret        = instret_reg;

endmodule

// File: tb/tb_ysyx_22050710_wb_stage.sv
// Scoreboard bench for the write-back stage: expectations are queued on accept
// and compared when the commit port fires.
module tb_ysyx_22050710_wb_stage;

   typedef struct {
      logic [63:0]  pc;
      logic [31:0]  inst;
      logic [63:0]  dnpc;
      logic         memen;
      logic [63:0]  memaddr;
      logic         rf_wen;
      logic [4:0]   rd;
      logic [63:0]  gres;
      logic         csr_wen;
      logic [11:0]  csr;
      logic [63:0]  cres;
      logic [144:0] bypass;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         ws_allowin;
   logic         ms_valid;
   logic [146:0] ms_bus;
   logic [224:0] dbg_bus;
   logic         commit_ready;
   logic         rf_wen;
   logic [4:0]   rf_waddr;
   logic [63:0]  rf_wdata;
   logic         csr_wen;
   logic [11:0]  csr_waddr;
   logic [63:0]  csr_wdata;
   logic [144:0] bypass;
   logic         commit_valid;
   logic [63:0]  commit_pc;
   logic [31:0]  commit_inst;
   logic [63:0]  commit_dnpc;
   logic         commit_memen;
   logic [63:0]  commit_memaddr;
   logic [63:0]  instret;

   exp_t        exp_q[$];
   logic [63:0] exp_instret;
   int          tests_run;
   int          tests_failed;
   int          commit_cnt;
   int          csr_pulse_cnt;
   logic [63:0] next_pc;

   ysyx_22050710_wb_stage dut (
      .i_clk                 (clk),
      .i_rst                 (rst_n),
      .o_ws_allowin          (ws_allowin),
      .i_ms_to_ws_valid      (ms_valid),
      .i_ms_to_ws_bus        (ms_bus),
      .i_debug_ms_to_ws_bus  (dbg_bus),
      .i_commit_ready        (commit_ready),
      .o_rf_wen              (rf_wen),
      .o_rf_waddr            (rf_waddr),
      .o_rf_wdata            (rf_wdata),
      .o_csr_wen             (csr_wen),
      .o_csr_waddr           (csr_waddr),
      .o_csr_wdata           (csr_wdata),
      .o_ws_to_ds_bypass_bus (bypass),
      .o_commit_valid        (commit_valid),
      .o_commit_pc           (commit_pc),
      .o_commit_inst         (commit_inst),
      .o_commit_dnpc         (commit_dnpc),
      .o_commit_memen        (commit_memen),
      .o_commit_memaddr      (commit_memaddr),
      .o_instret             (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: every commit pops one expectation; idle cycles must not write
   always @(negedge clk) begin
      if (rst_n) begin
         if (commit_valid) begin
            if (exp_q.size() == 0) begin
               check_val("unexpected_commit", {192'd0, commit_pc}, 256'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check_val("commit_pc", {192'd0, commit_pc}, {192'd0, e.pc});
               check_val("commit_inst", {224'd0, commit_inst}, {224'd0, e.inst});
               check_val("commit_dnpc", {192'd0, commit_dnpc}, {192'd0, e.dnpc});
               check_val("commit_mem", {191'd0, commit_memen, commit_memaddr},
                         {191'd0, e.memen, e.memaddr});
               check_val("rf_wen", {255'd0, rf_wen}, {255'd0, e.rf_wen});
               check_val("rf_wdata", {187'd0, rf_waddr, rf_wdata}, {187'd0, e.rd, e.gres});
               check_val("csr_wen", {255'd0, csr_wen}, {255'd0, e.csr_wen});
               check_val("csr_wdata", {180'd0, csr_waddr, csr_wdata}, {180'd0, e.csr, e.cres});
               check_val("bypass", {111'd0, bypass}, {111'd0, e.bypass});
               check_val("instret_at_commit", {192'd0, instret}, {192'd0, exp_instret});
               $display("[TB] commit pc=%0h inst=%0h instret=%0d", commit_pc, commit_inst, instret);
               exp_instret = exp_instret + 64'd1;
               commit_cnt++;
               if (csr_wen) csr_pulse_cnt++;
            end
         end else begin
            check_val("idle_no_write", {254'd0, rf_wen, csr_wen}, 256'd0);
         end
      end
   end

   function automatic logic [144:0] bypass_of(input logic gw, input logic [4:0] rd,
                                              input logic [63:0] gres, input logic cw,
                                              input logic [11:0] csr, input logic [63:0] cres);
      logic [144:0] b;
      b = '0;
      if (gw) b[144:76] = {rd, gres};
      if (cw) b[75:0]   = {csr, cres};
      return b;
   endfunction

   // Offer one instruction, wait (bounded) until it is accepted, queue its expectation
   task automatic send(input logic gw, input logic [4:0] rd, input logic [63:0] gres,
                       input logic cw, input logic [11:0] csr, input logic [63:0] cres);
      exp_t e;
      int   waited;
      e.pc      = next_pc;
      e.inst    = $urandom;
      e.dnpc    = next_pc + 64'd4;
      e.memen   = 1'($urandom_range(0, 1));
      e.memaddr = {$urandom, $urandom};
      e.rf_wen  = gw && (rd != 5'd0);
      e.rd      = rd;
      e.gres    = gres;
      e.csr_wen = cw;
      e.csr     = csr;
      e.cres    = cres;
      e.bypass  = bypass_of(gw, rd, gres, cw, csr, cres);
      next_pc   = next_pc + 64'd4;
      ms_valid  = 1'b1;
      ms_bus    = {gw, rd, gres, cw, csr, cres};
      dbg_bus   = {e.inst, e.pc, e.dnpc, e.memen, e.memaddr};
      waited    = 0;
      @(negedge clk);
      while (!ws_allowin && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      if (!ws_allowin) check_val("accept_timeout", 256'd0, 256'd1);
      else exp_q.push_back(e);
      @(posedge clk);
      #1;
      ms_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      check_val("drain", 256'(exp_q.size()), 256'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] base_instret;
      int          base_commits;
      tests_run     = 0;
      tests_failed  = 0;
      commit_cnt    = 0;
      csr_pulse_cnt = 0;
      exp_instret   = 64'd0;
      next_pc       = 64'h8000_0000;
      rst_n         = 1'b0;
      ms_valid      = 1'b0;
      ms_bus        = '0;
      dbg_bus       = '0;
      commit_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_val("rst_allowin", {255'd0, ws_allowin}, 256'd1);
      check_val("rst_outputs", {253'd0, commit_valid, rf_wen, csr_wen}, 256'd0);
      check_val("rst_instret", {192'd0, instret}, 256'd0);
      check_val("rst_bypass", {111'd0, bypass}, 256'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single ALU op to x5
      send(1'b1, 5'd5, 64'h1234, 1'b0, 12'd0, 64'd0);
      drain();
      check_val("instret_after_alu", {192'd0, instret}, 256'd1);

      // write to x0 is suppressed but still retires
      send(1'b1, 5'd0, 64'hdead_beef, 1'b0, 12'd0, 64'd0);
      drain();
      check_val("instret_after_x0", {192'd0, instret}, {192'd0, exp_instret});

      // CSR write stalled for 3 cycles
      commit_ready  = 1'b0;
      csr_pulse_cnt = 0;
      base_instret  = exp_instret;
      send(1'b0, 5'd0, 64'd0, 1'b1, 12'h341, 64'h8000_0004);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("stall_allowin", {255'd0, ws_allowin}, 256'd0);
         check_val("stall_bypass", {111'd0, bypass},
                   {111'd0, bypass_of(1'b0, 5'd0, 64'd0, 1'b1, 12'h341, 64'h8000_0004)});
         check_val("stall_instret", {192'd0, instret}, {192'd0, base_instret});
      end
      @(posedge clk);
      #1;
      commit_ready = 1'b1;
      drain();
      check_val("csr_pulses", 256'(csr_pulse_cnt), 256'd1);
      check_val("instret_after_csr", {192'd0, instret}, {192'd0, base_instret + 64'd1});

      // 10 back-to-back instructions
      base_commits = commit_cnt;
      base_instret = exp_instret;
      for (int i = 0; i < 10; i++) begin
         send(1'b1, 5'(i + 1), {$urandom, $urandom}, 1'(i % 3 == 0), 12'(i * 7), {$urandom, $urandom});
         check_val("b2b_allowin", {255'd0, ws_allowin}, 256'd1);
      end
      drain();
      check_val("b2b_commits", 256'(commit_cnt - base_commits), 256'd10);
      check_val("b2b_instret", {192'd0, instret}, {192'd0, base_instret + 64'd10});

      // instret wrap
      force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_reg;
      exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      send(1'b1, 5'd9, 64'h55, 1'b0, 12'd0, 64'd0);
      drain();
      check_val("instret_wrap", {192'd0, instret}, 256'd0);

      // reset during a stall discards the held instruction
      commit_ready = 1'b0;
      base_commits = commit_cnt;
      send(1'b1, 5'd7, 64'h77, 1'b1, 12'h300, 64'h88);
      @(negedge clk);
      check_val("pre_rst_stall_allowin", {255'd0, ws_allowin}, 256'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      exp_instret = 64'd0;
      @(negedge clk);
      check_val("rst_stall_allowin", {255'd0, ws_allowin}, 256'd1);
      check_val("rst_stall_instret", {192'd0, instret}, 256'd0);
      check_val("rst_stall_bypass", {111'd0, bypass}, 256'd0);
      commit_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_stall_no_commit", 256'(commit_cnt - base_commits), 256'd0);
      check_val("rst_stall_instret_hold", {192'd0, instret}, 256'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ysyx_22050710_wb_stage.md
Name: ysyx_22050710_wb_stage

Overview:
Write-back stage: the last pipeline stage, directly downstream of the memory stage. It accepts one retiring instruction per cycle over the valid/allowin handshake and latches the ms-to-ws bus. It drives the GPR and CSR file write ports, a forwarding bus back to decode, and a commit/difftest port with backpressure. It also keeps a 64-bit retired-instruction counter.

Parameters:
WORD_WD, 64, GPR/CSR data width
PC_WD, 64, PC width
INST_WD, 32, instruction width
GPR_ADDR_WD, 5, GPR index width
CSR_ADDR_WD, 12, CSR address width
MS_TO_WS_BUS_WD, 147, equals 2+GPR_ADDR_WD+CSR_ADDR_WD+2*WORD_WD
BYPASS_BUS_WD, 145, equals GPR_ADDR_WD+CSR_ADDR_WD+2*WORD_WD
DEBUG_BUS_WD, 225, equals INST_WD+2*PC_WD+1+WORD_WD

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  synchronous, active-low reset; state resets on an edge where i_rst==0
o_ws_allowin  out  1  ws can accept an instruction this cycle
i_ms_to_ws_valid  in  1  ms offers an instruction
i_ms_to_ws_bus  in  MS_TO_WS_BUS_WD  {gpr_wen, rd, gpr_result, csr_wen, csr, csr_result}, MSB first
i_debug_ms_to_ws_bus  in  DEBUG_BUS_WD  {inst, pc, dnpc, memen, memaddr}, MSB first
i_commit_ready  in  1  commit consumer accepts the retiring instruction
o_rf_wen  out  1  GPR write enable
o_rf_waddr  out  GPR_ADDR_WD  GPR write index
o_rf_wdata  out  WORD_WD  GPR write data
o_csr_wen  out  1  CSR write enable
o_csr_waddr  out  CSR_ADDR_WD  CSR write address
o_csr_wdata  out  WORD_WD  CSR write data
o_ws_to_ds_bypass_bus  out  BYPASS_BUS_WD  forwarding bus {rd, gpr_data, csr, csr_data}
o_commit_valid  out  1  instruction retiring this cycle
o_commit_pc  out  PC_WD  PC of the retiring instruction
o_commit_inst  out  INST_WD  instruction word of the retiring instruction
o_commit_dnpc  out  PC_WD  next PC of the retiring instruction
o_commit_memen  out  1  retiring instruction accessed memory
o_commit_memaddr  out  WORD_WD  memory address of the retiring instruction
o_instret  out  64  count of retired instructions

Behaviour:
- State:
  - ws_valid register.
  - Payload register holding the ms bus and debug bus.
  - instret counter, 64 bits.
- Handshake:
  - ws_ready_go = i_commit_ready.
  - o_ws_allowin = !ws_valid || (ws_ready_go).
  - ws_valid is loaded with i_ms_to_ws_valid when o_ws_allowin is high.
  - Payload is loaded only when i_ms_to_ws_valid && o_ws_allowin.
  - Latency: an instruction accepted at edge N is visible from cycle N (registered outputs follow edge N).
- Retire:
  - retire = ws_valid && ws_ready_go.
  - o_commit_valid = retire.
  - The commit_* fields come from the payload register at all times and are meaningful only when o_commit_valid is high.
- Register-file writes occur only on retire:
  - o_rf_wen = retire && gpr_wen && (rd != 0). Writes to x0 are suppressed.
  - o_csr_wen = retire && csr_wen.
  - waddr/wdata always come from the payload.
- Forwarding bus:
  - The whole bus is masked by ws_valid (not by retire), so a stalled instruction still forwards its result.
  - rd and gpr_data fields are zeroed when gpr_wen==0.
  - csr and csr_data fields are zeroed when csr_wen==0.
  - An entry with rd==0 forwards rd=0.
- instret:
  - Increments by 1 at each edge where retire is high.
  - Wraps from 2^64-1 to 0.
- Stall: while i_commit_ready is low and ws_valid is high:
  - allowin is 0, the payload holds, no RF/CSR writes occur, and instret holds.
- Back-to-back: with i_commit_ready held high, one instruction is accepted and one retired every cycle, and the payload is replaced on the same edge.
- Reset (i_rst==0 at an edge):
  - ws_valid=0, payload=0, instret=0.
  - Hence o_rf_wen=0, o_csr_wen=0, o_commit_valid=0, bypass bus all zeros, and o_ws_allowin=1.
  - Reset asserted mid-stall discards the held instruction; it does not retire and instret does not count it.
- Simultaneous accept and retire in the same cycle: the old payload retires (writes use the old data), and the new payload is latched at the edge.

Test Plan:
- Reset, then single ALU op rd=5, result=0x1234, commit_ready=1 -> one cycle with o_rf_wen=1, waddr=5, wdata=0x1234, o_commit_valid=1; instret goes 0->1.
- rd=0 with gpr_wen=1 -> o_rf_wen=0; bypass rd field=0; commit_valid=1; instret increments.
- CSR write csr=0x341, data=0x80000004, with commit_ready=0 for 3 cycles -> no o_csr_wen and allowin=0 during the stall; bypass shows 0x341/0x80000004 all 3 cycles; on release, exactly one o_csr_wen pulse and instret+1.
- 10 back-to-back instructions with commit_ready=1 -> 10 consecutive commit_valid pulses, PCs in order, instret=10, allowin constantly 1.
- Preload instret to near-max via a long run (or force to 0xFFFF_FFFF_FFFF_FFFF) then retire one -> instret=0.
- Stall with a valid instruction, assert i_rst=0 for one edge -> commit_valid never pulses for it, instret=0, allowin=1, bypass bus=0.
